// File: rtl/baggage_drop_ctrl.sv
// Baggage-drop sequencing controller.
// A transaction starts in IDLE: the limit is latched, then a burst of sensor samples is averaged.
// The drop stage is then armed for a fixed window, and its feedback is recorded as the result.
// Every output comes straight from a register, so no input reaches an output combinationally.
module baggage_drop_ctrl #(
    parameter int unsigned NUM_SAMPLES_LOG2 = 2,
    parameter int unsigned DROP_CYCLES      = 8,
    parameter int unsigned SAMPLE_TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] t_lim_in,
    input  logic        sensor_valid,
    input  logic [15:0] sensor_data,
    input  logic        drop_activated,
    output logic [15:0] t_act,
    output logic [15:0] t_lim,
    output logic        drop_en,
    output logic        busy,
    output logic        done,
    output logic        dropped,
    output logic        timeout,
    output logic        mismatch
);

    localparam int unsigned NumSamples = 1 << NUM_SAMPLES_LOG2;
    // Wide enough that NumSamples full-scale samples cannot overflow.
    localparam int unsigned AccW       = 16 + NUM_SAMPLES_LOG2;
    localparam int unsigned CntW       = NUM_SAMPLES_LOG2 + 1;
    localparam int unsigned IdleW      = $clog2(SAMPLE_TIMEOUT + 1);
    localparam int unsigned DropW      = $clog2(DROP_CYCLES + 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSample = 2'd1;
    localparam logic [1:0] StArm    = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    logic [1:0]       state_q,    state_d;
    logic [AccW-1:0]  acc_q,      acc_d;
    logic [CntW-1:0]  cnt_q,      cnt_d;
    logic [IdleW-1:0] idle_q,     idle_d;
    logic [DropW-1:0] drop_cnt_q, drop_cnt_d;
    logic [15:0]      t_act_q,    t_act_d;
    logic [15:0]      t_lim_q,    t_lim_d;
    logic             drop_en_q,  drop_en_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             dropped_q,  dropped_d;
    logic             timeout_q,  timeout_d;
    logic             mismatch_q, mismatch_d;

    logic [AccW-1:0]  acc_sum;
    logic             last_sample;
    logic             idle_expired;
    logic             arm_last;
    logic             expect_drop;

    // Helper terms shared by the next-state logic below.
    always_comb begin
        acc_sum      = acc_q + AccW'(sensor_data);
        last_sample  = (cnt_q == CntW'(NumSamples - 1));
        idle_expired = (idle_q == IdleW'(SAMPLE_TIMEOUT - 1));
        arm_last     = (drop_cnt_q == DropW'(1));
        // The decision the drop stage should make from the values we drive it (unsigned).
        expect_drop  = (t_act_q < t_lim_q);
    end

    // Next-state and next-output decode for the transaction sequence.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        idle_d     = idle_q;
        drop_cnt_d = drop_cnt_q;
        t_act_d    = t_act_q;
        t_lim_d    = t_lim_q;
        drop_en_d  = drop_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dropped_d  = dropped_q;
        timeout_d  = timeout_q;
        mismatch_d = mismatch_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    t_lim_d    = t_lim_in;
                    t_act_d    = '0;
                    acc_d      = '0;
                    cnt_d      = '0;
                    idle_d     = '0;
                    dropped_d  = 1'b0;
                    timeout_d  = 1'b0;
                    mismatch_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = StSample;
                end
            end

            StSample: begin
                if (sensor_valid) begin
                    acc_d  = acc_sum;
                    cnt_d  = cnt_q + CntW'(1);
                    idle_d = '0;
                    if (last_sample) begin
                        // Floor average, including the sample accepted this cycle.
                        t_act_d    = 16'(acc_sum >> NUM_SAMPLES_LOG2);
                        drop_en_d  = 1'b1;
                        drop_cnt_d = DropW'(DROP_CYCLES);
                        state_d    = StArm;
                    end
                end else if (idle_expired) begin
                    // Sensor went quiet: abandon the partial average, never arm.
                    idle_d    = '0;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = StDone;
                end else begin
                    idle_d = idle_q + IdleW'(1);
                end
            end

            StArm: begin
                if (drop_activated) begin
                    dropped_d = 1'b1;
                end
                if (drop_activated != expect_drop) begin
                    mismatch_d = 1'b1;
                end
                if (arm_last) begin
                    drop_cnt_d = '0;
                    drop_en_d  = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = StDone;
                end else begin
                    drop_cnt_d = drop_cnt_q - DropW'(1);
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d   = StIdle;
                drop_en_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            cnt_q      <= '0;
            idle_q     <= '0;
            drop_cnt_q <= '0;
            t_act_q    <= '0;
            t_lim_q    <= '0;
            drop_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dropped_q  <= 1'b0;
            timeout_q  <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            drop_cnt_q <= drop_cnt_d;
            t_act_q    <= t_act_d;
            t_lim_q    <= t_lim_d;
            drop_en_q  <= drop_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dropped_q  <= dropped_d;
            timeout_q  <= timeout_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign t_act    = t_act_q;
    assign t_lim    = t_lim_q;
    assign drop_en  = drop_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign dropped  = dropped_q;
    assign timeout  = timeout_q;
    assign mismatch = mismatch_q;

endmodule

// File: tb/tb_baggage_drop_ctrl.sv
// Self-checking bench for baggage_drop_ctrl at default parameters.
// Expected values come from transaction-level arithmetic: floor average, unsigned compare, cycle counts.
module tb_baggage_drop_ctrl;

    localparam int DropCycles = 8;
    localparam int Timeout    = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] t_lim_in;
    logic        sensor_valid;
    logic [15:0] sensor_data;
    logic        drop_activated;
    logic [15:0] t_act;
    logic [15:0] t_lim;
    logic        drop_en;
    logic        busy;
    logic        done;
    logic        dropped;
    logic        timeout;
    logic        mismatch;

    // Drop-stage model: drops when the driven average is below the driven limit, unless forced.
    logic        frc     = 1'b0;
    logic        frc_val = 1'b0;
    assign drop_activated = frc ? frc_val : (t_act < t_lim);

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] smp [4];
    int          last_done;

    baggage_drop_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .t_lim_in       (t_lim_in),
        .sensor_valid   (sensor_valid),
        .sensor_data    (sensor_data),
        .drop_activated (drop_activated),
        .t_act          (t_act),
        .t_lim          (t_lim),
        .drop_en        (drop_en),
        .busy           (busy),
        .done           (done),
        .dropped        (dropped),
        .timeout        (timeout),
        .mismatch       (mismatch)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_t_act"},    32'(t_act),    0);
        check({tag, "_t_lim"},    32'(t_lim),    0);
        check({tag, "_drop_en"},  32'(drop_en),  0);
        check({tag, "_busy"},     32'(busy),     0);
        check({tag, "_done"},     32'(done),     0);
        check({tag, "_dropped"},  32'(dropped),  0);
        check({tag, "_timeout"},  32'(timeout),  0);
        check({tag, "_mismatch"}, 32'(mismatch), 0);
    endtask

    // One full transaction with samples from smp[], gap idle cycles before each sample.
    task automatic run_txn(input string tag, input logic [15:0] lim, input int gap,
                           input bit force_en, input bit force_v, input bit poke);
        int sum, avg, e, k, en_cnt, first_en, done_cyc;
        bit exp_below, exp_drop, exp_mm;
        sum = 0;
        for (int i = 0; i < 4; i++) sum += int'(smp[i]);
        avg       = sum / 4;
        exp_below = (avg < int'(lim));
        exp_drop  = force_en ? force_v : exp_below;
        exp_mm    = force_en && (force_v != exp_below);
        frc       = force_en;
        frc_val   = force_v;

        start    = 1'b1;
        t_lim_in = lim;
        tick;
        e     = 0;
        start = 1'b0;
        check({tag, "_busy_cycle1"}, 32'(busy), 1);
        check({tag, "_t_act_cleared"}, 32'(t_act), 0);
        check({tag, "_dropped_cleared"}, 32'(dropped), 0);

        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) begin
                sensor_valid = 1'b0;
                sensor_data  = 16'($urandom);
                if (poke) begin
                    start    = 1'($urandom);
                    t_lim_in = 16'($urandom);
                end
                tick;
                e++;
                check({tag, "_no_drop_en_sample"}, 32'(drop_en), 0);
            end
            sensor_valid = 1'b1;
            sensor_data  = smp[i];
            tick;
            e++;
        end
        k            = e;
        sensor_valid = 1'b0;

        en_cnt   = 0;
        first_en = 0;
        done_cyc = 0;
        for (int j = 0; j < DropCycles + 10; j++) begin
            if (drop_en) begin
                en_cnt++;
                if (en_cnt == 1) begin
                    first_en = e + 1;
                    check({tag, "_t_act_avg"}, 32'(t_act), 32'(avg));
                    check({tag, "_t_lim"}, 32'(t_lim), 32'(lim));
                end
            end
            if (done) begin
                done_cyc = e + 1;
                break;
            end
            if (poke) begin
                start        = 1'($urandom);
                t_lim_in     = 16'($urandom);
                sensor_valid = 1'($urandom);
                sensor_data  = 16'($urandom);
            end
            tick;
            e++;
        end
        last_done = done_cyc;
        check({tag, "_drop_en_first"}, 32'(first_en), 32'(k + 1));
        check({tag, "_drop_en_cycles"}, 32'(en_cnt), DropCycles);
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(k + DropCycles + 1));
        check({tag, "_done_drop_en"}, 32'(drop_en), 0);
        check({tag, "_done_busy"}, 32'(busy), 0);
        check({tag, "_dropped"}, 32'(dropped), 32'(exp_drop));
        check({tag, "_mismatch"}, 32'(mismatch), 32'(exp_mm));
        check({tag, "_timeout"}, 32'(timeout), 0);
        check({tag, "_t_lim_kept"}, 32'(t_lim), 32'(lim));

        // start in DONE must be ignored
        start        = poke;
        t_lim_in     = 16'($urandom);
        sensor_valid = 1'b0;
        tick;
        start = 1'b0;
        frc   = 1'b0;
        check({tag, "_idle_done"}, 32'(done), 0);
        check({tag, "_idle_busy"}, 32'(busy), 0);
        check({tag, "_idle_dropped_held"}, 32'(dropped), 32'(exp_drop));
        check({tag, "_idle_t_act_held"}, 32'(t_act), 32'(avg));
    endtask

    // Transaction that delivers nsamp samples then lets the sensor go quiet.
    task automatic run_timeout(input string tag, input int nsamp);
        int  e, done_cyc;
        bit  saw_en;
        start    = 1'b1;
        t_lim_in = 16'hffff;
        tick;
        e     = 0;
        start = 1'b0;
        for (int i = 0; i < nsamp; i++) begin
            sensor_valid = 1'b1;
            sensor_data  = 16'(100 + i);
            tick;
            e++;
        end
        sensor_valid = 1'b0;
        saw_en       = 1'b0;
        done_cyc     = 0;
        for (int j = 0; j < Timeout + 20; j++) begin
            if (drop_en) saw_en = 1'b1;
            if (done) begin
                done_cyc = e + 1;
                break;
            end
            tick;
            e++;
        end
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(nsamp + Timeout + 1));
        check({tag, "_timeout"}, 32'(timeout), 1);
        check({tag, "_dropped"}, 32'(dropped), 0);
        check({tag, "_mismatch"}, 32'(mismatch), 0);
        check({tag, "_never_armed"}, 32'(saw_en), 0);
        check({tag, "_t_act_unset"}, 32'(t_act), 0);
        tick;
        check({tag, "_idle_busy"}, 32'(busy), 0);
        check({tag, "_timeout_held"}, 32'(timeout), 1);
    endtask

    initial begin
        bit saw_done;
        rst_n        = 1'b0;
        start        = 1'b1;
        sensor_valid = 1'b1;
        sensor_data  = 16'd123;
        t_lim_in     = 16'd77;
        tick;
        tick;
        tick;
        check_all_zero("reset");
        rst_n        = 1'b1;
        start        = 1'b0;
        sensor_valid = 1'b0;
        tick;
        check("reset_release_busy", 32'(busy), 0);

        smp = '{16'd40, 16'd50, 16'd60, 16'd70};
        run_txn("cold", 16'd100, 0, 1'b0, 1'b0, 1'b0);
        check("cold_done_13", 32'(last_done), 13);

        smp = '{16'd200, 16'd200, 16'd200, 16'd200};
        run_txn("hot", 16'd100, 0, 1'b0, 1'b0, 1'b0);

        smp = '{16'd100, 16'd100, 16'd100, 16'd100};
        run_txn("equal", 16'd100, 0, 1'b0, 1'b0, 1'b0);

        smp = '{16'd1, 16'd2, 16'd2, 16'd2};
        run_txn("trunc", 16'd50, 3, 1'b0, 1'b0, 1'b0);
        run_txn("forced", 16'd0, 3, 1'b1, 1'b1, 1'b0);

        smp = '{16'hffff, 16'hffff, 16'hffff, 16'hfffe};
        run_txn("fullscale", 16'hffff, 1, 1'b0, 1'b0, 1'b1);

        run_timeout("tmo_partial", 2);
        run_timeout("tmo_empty", 0);

        // Reset on the 4th ARM cycle
        start    = 1'b1;
        t_lim_in = 16'd100;
        tick;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sensor_valid = 1'b1;
            sensor_data  = 16'd10;
            tick;
        end
        sensor_valid = 1'b0;
        tick;
        tick;
        tick;
        check("rst_arm_drop_en_before", 32'(drop_en), 1);
        rst_n = 1'b0;
        tick;
        check_all_zero("rst_arm");
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done || busy || drop_en) saw_done = 1'b1;
        end
        check("rst_arm_stays_idle", 32'(saw_done), 0);

        // Randomized transactions with start pokes while busy
        for (int n = 0; n < 16; n++) begin
            logic [15:0] lim;
            int          gap;
            bit          fe, fv;
            if (n % 3 == 0) begin
                for (int i = 0; i < 4; i++) smp[i] = 16'($urandom);
                lim = 16'($urandom);
            end else begin
                for (int i = 0; i < 4; i++) smp[i] = 16'($urandom_range(0, 400));
                lim = 16'($urandom_range(0, 300));
            end
            gap = $urandom_range(0, 2);
            fe  = ($urandom_range(0, 3) == 0);
            fv  = 1'($urandom);
            run_txn("rand", lim, gap, fe, fv, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/baggage_drop_ctrl.md
# baggage_drop_ctrl

Sequencing controller for the baggage-drop display/drop stage. It latches a temperature limit on a start request and averages a burst of sensor samples into `t_act`. It then arms the drop stage by holding `drop_en` for a fixed window and records the stage's `drop_activated` feedback as the transaction result. It sits between the sensor front end and the combinational display/drop block, and drives that block's `t_act`, `t_lim` and `drop_en` inputs.

## Interface
- `NUM_SAMPLES_LOG2`, default 2: log2 of the number of samples averaged per transaction (N = 4).
- `DROP_CYCLES`, default 8: number of cycles `drop_en` is held high; must be ≥1.
- `SAMPLE_TIMEOUT`, default 255: maximum consecutive cycles without `sensor_valid` in SAMPLE; must be ≥1.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `start`, input, 1: transaction request; sampled only in IDLE.
- `t_lim_in`, input, 16: limit value, latched when `start` is accepted.
- `sensor_valid`, input, 1: `sensor_data` is valid this cycle.
- `sensor_data`, input, 16: unsigned temperature sample.
- `drop_activated`, input, 1: feedback from the display/drop stage.
- `t_act`, output, 16: registered average driven to the drop stage.
- `t_lim`, output, 16: registered limit driven to the drop stage.
- `drop_en`, output, 1: registered arm signal to the drop stage.
- `busy`, output, 1: high in SAMPLE and ARM.
- `done`, output, 1: one-cycle pulse in DONE.
- `dropped`, output, 1: result; held from DONE until the next accepted start.
- `timeout`, output, 1: sample timeout occurred; held like `dropped`.
- `mismatch`, output, 1: feedback disagreed with the expected decision; held like `dropped`.

## Operation
- States are IDLE, SAMPLE, ARM and DONE.
- **Reset** (`rst_n`=0 at an edge): state goes to IDLE. All outputs, the accumulator and all counters go to 0. Reset takes priority in every state, including mid-SAMPLE and mid-ARM, and `drop_en` drops on that edge.
- **IDLE:** on `start`=1:
  - latch `t_lim` ← `t_lim_in`;
  - clear `t_act`, the accumulator, the sample count, the idle counter, `dropped`, `timeout` and `mismatch`;
  - go to SAMPLE.
- **SAMPLE:**
  - Each cycle with `sensor_valid`=1 adds zero-extended `sensor_data` to a (16+`NUM_SAMPLES_LOG2`)-bit accumulator, which cannot overflow. The sample count increments and the idle counter clears.
  - On the cycle accepting sample N, go to ARM and load `t_act` ← accumulator-including-this-sample >> `NUM_SAMPLES_LOG2`. This is a floor average.
  - Each cycle with `sensor_valid`=0 increments the idle counter. When it would reach `SAMPLE_TIMEOUT`, go to DONE with `timeout`←1; ARM is skipped and `drop_en` is never asserted.
  - `start` is ignored.
- **ARM:**
  - `drop_en`=1 for exactly `DROP_CYCLES` cycles, counted by a down-counter, then go to DONE.
  - Each ARM cycle with `drop_activated`=1 sets the sticky `dropped`.
  - Each ARM cycle where `drop_activated` ≠ (`t_act` < `t_lim`) sets the sticky `mismatch`. The comparison is unsigned; equality gives expected 0.
  - `start` and `sensor_valid` are ignored.
- **DONE:** one cycle with `done`=1, `busy`=0 and `drop_en`=0, then go to IDLE. `start` is ignored in DONE.
- `t_act` and `t_lim` hold their values until the next accepted start.

## Timing
- `start` accepted at edge 0 → SAMPLE from cycle 1, with `busy`=1 from cycle 1.
- Nth sample accepted at edge k → `t_act` valid and `drop_en`=1 from cycle k+1 through k+`DROP_CYCLES`.
- `done`=1 in cycle k+`DROP_CYCLES`+1 with final `dropped`/`mismatch`; IDLE follows the next cycle.
- Minimum transaction: N=4 back-to-back samples from cycle 1 → `done` in cycle 4+`DROP_CYCLES`+1 = 13 (defaults).
- Timeout with no samples: `done` in cycle `SAMPLE_TIMEOUT`+1 = 256 (defaults).
- `drop_activated` is combinational from the registered outputs and is sampled in the same cycle.
- Every output is registered; there is no combinational path from any input to any output.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `start`=1 and `sensor_valid`=1 → all outputs 0, state IDLE, no `busy`.
- **Cold drop:** `t_lim_in`=100, samples 40,50,60,70 back-to-back, drop stage model attached → `t_act`=55, `drop_en` high exactly 8 cycles, `done` at cycle 13, `dropped`=1, `mismatch`=0, `timeout`=0.
- **Hot and equal:**
  - samples 200×4 with `t_lim_in`=100 → `dropped`=0, `mismatch`=0;
  - samples 100×4 with `t_lim_in`=100 → `t_act`=100, `dropped`=0, `mismatch`=0.
- **Truncation and gaps:** samples 1,2,2,2 with 3 idle cycles between each → `t_act`=1. A forced `drop_activated`=1 during ARM with `t_lim_in`=0 → `dropped`=1, `mismatch`=1.
- **Timeout:** `start`, then 2 samples, then `sensor_valid`=0 for 255 cycles → `done` with `timeout`=1. `drop_en` is never high, and the partial result is ignored.
- **Reset mid-ARM and start while busy:**
  - `rst_n`=0 on the 4th ARM cycle → `drop_en`=0 and IDLE on that edge, no `done`;
  - `start` pulses during SAMPLE/ARM/DONE → ignored, and `t_lim` is unchanged.
